// File: rtl/updown_param.sv
// updown_param: parameterised up/down counter with parallel load, terminal-count
// decodes and registered carry/borrow pulses. Wraps modulo MAX_VAL+1 or saturates.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  terminal count (1..2**WIDTH-1)
//   STEP     increment/decrement magnitude (1..MAX_VAL)
//   SATURATE 0 = wrap, 1 = saturate
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   load     synchronous parallel load strobe (highest priority)
//   ld       load value, clamped to MAX_VAL
//   cnt_en   count enable, gates up/down only
//   up       count-up request
//   down     count-down request (up & down together hold)
//   q        registered count
//   tc_up    high when q == MAX_VAL
//   tc_dn    high when q == 0
//   carry    registered pulse: an up step passed MAX_VAL
//   borrow   registered pulse: a down step went below 0
//   flag_clr synchronous clear of sticky flags         (UPDOWN_PARAM_STICKY_FLAGS_EN only)
//   ovf_flag sticky overflow, set by carry             (UPDOWN_PARAM_STICKY_FLAGS_EN only)
//   unf_flag sticky underflow, set by borrow           (UPDOWN_PARAM_STICKY_FLAGS_EN only)
//
// Optional feature macro: UPDOWN_PARAM_STICKY_FLAGS_EN
module updown_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP     = 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld,
  input  logic             cnt_en,
  input  logic             up,
  input  logic             down,
`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
  input  logic             flag_clr,
  output logic             ovf_flag,
  output logic             unf_flag,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             carry,
  output logic             borrow
);

  // MAX_VAL+1 needs WIDTH+1 bits when MAX_VAL = 2**WIDTH-1.
  localparam longint unsigned ModVal  = MAX_VAL + 64'd1;
  localparam logic [WIDTH-1:0] MaxVal  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] StepVal = STEP[WIDTH-1:0];
  localparam logic [WIDTH:0]   MaxExt  = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0]   StepExt = STEP[WIDTH:0];
  localparam logic [WIDTH:0]   ModExt  = ModVal[WIDTH:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wrap_up, wrap_dn;

  always_comb begin
    sum     = {1'b0, q_q} + StepExt;
    wrap_up = WIDTH'(sum - ModExt);
    // Only used when q < STEP, so STEP - q is positive and the result <= MAX_VAL.
    wrap_dn = WIDTH'(ModExt - (StepExt - {1'b0, q_q}));
  end

  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      q_d = ({1'b0, ld} > MaxExt) ? MaxVal : ld;
    end else if (cnt_en && up && down) begin
      q_d = q_q;
    end else if (cnt_en && up) begin
      if (sum > MaxExt) begin
        carry_d = 1'b1;
        q_d     = SATURATE ? MaxVal : wrap_up;
      end else begin
        q_d = sum[WIDTH-1:0];
      end
    end else if (cnt_en && down) begin
      if (q_q >= StepVal) begin
        q_d = q_q - StepVal;
      end else begin
        borrow_d = 1'b1;
        q_d      = SATURATE ? '0 : wrap_dn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = q_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign tc_up  = (q_q == MaxVal);
  assign tc_dn  = (q_q == '0);

`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
  logic ovf_q, unf_q;

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= carry_d | (ovf_q & ~flag_clr);
      unf_q <= borrow_d | (unf_q & ~flag_clr);
    end
  end

  assign ovf_flag = ovf_q;
  assign unf_flag = unf_q;
`endif

endmodule

// File: tb/tb_updown_param.sv
// Directed self-checking bench for updown_param. Three instances share stimulus:
//   w: WIDTH=4 MAX_VAL=9 STEP=1 wrap
//   s: WIDTH=4 MAX_VAL=9 STEP=1 saturate
//   f: WIDTH=4 MAX_VAL=9 STEP=4 wrap
module tb_updown_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] ld = 4'd0;
  logic       cnt_en = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       flag_clr = 1'b0;

  logic [3:0] w_q, s_q, f_q;
  logic       w_tc_up, w_tc_dn, w_carry, w_borrow;
  logic       s_tc_up, s_tc_dn, s_carry, s_borrow;
  logic       f_tc_up, f_tc_dn, f_carry, f_borrow;
  logic       w_ovf, w_unf, s_ovf, s_unf, f_ovf, f_unf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst(rst), .load(load), .ld(ld), .cnt_en(cnt_en), .up(up), .down(down),
`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .ovf_flag(w_ovf), .unf_flag(w_unf),
`endif
    .q(w_q), .tc_up(w_tc_up), .tc_dn(w_tc_dn), .carry(w_carry), .borrow(w_borrow)
  );

  updown_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .load(load), .ld(ld), .cnt_en(cnt_en), .up(up), .down(down),
`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .ovf_flag(s_ovf), .unf_flag(s_unf),
`endif
    .q(s_q), .tc_up(s_tc_up), .tc_dn(s_tc_dn), .carry(s_carry), .borrow(s_borrow)
  );

  updown_param #(.WIDTH(4), .MAX_VAL(9), .STEP(4), .SATURATE(1'b0)) u_f (
    .clk(clk), .rst(rst), .load(load), .ld(ld), .cnt_en(cnt_en), .up(up), .down(down),
`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .ovf_flag(f_ovf), .unf_flag(f_unf),
`endif
    .q(f_q), .tc_up(f_tc_up), .tc_dn(f_tc_dn), .carry(f_carry), .borrow(f_borrow)
  );

`ifndef UPDOWN_PARAM_STICKY_FLAGS_EN
  assign w_ovf = 1'b0;
  assign w_unf = 1'b0;
  assign s_ovf = 1'b0;
  assign s_unf = 1'b0;
  assign f_ovf = 1'b0;
  assign f_unf = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, clock once, and land 1 time unit after the edge.
  task automatic cycle(input logic l, input logic [3:0] v, input logic e, input logic u,
                       input logic d);
    load   = l;
    ld     = v;
    cnt_en = e;
    up     = u;
    down   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, checked before any clock edge.
    #3;
    check("rst_q", 32'(w_q), 0);
    check("rst_tc_dn", 32'(w_tc_dn), 1);
    check("rst_tc_up", 32'(w_tc_up), 0);
    check("rst_carry", 32'(w_carry), 0);
    check("rst_borrow", 32'(w_borrow), 0);
    @(negedge clk);
    rst = 1'b1;

    // Count up 10 cycles in wrap mode: 1..9 then 0 with carry.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("up_q", 32'(w_q), 32'(i % 10));
      check("up_carry", 32'(w_carry), (i == 10) ? 1 : 0);
      check("up_tc_up", 32'(w_tc_up), (i == 9) ? 1 : 0);
    end
    check("up_tc_dn_at0", 32'(w_tc_dn), 1);

    // Down from 0 wraps to 9 with a single borrow pulse.
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    check("dn_wrap_q", 32'(w_q), 9);
    check("dn_wrap_borrow", 32'(w_borrow), 1);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("dn_hold_q", 32'(w_q), 9);
    check("dn_borrow_pulse_end", 32'(w_borrow), 0);

    // Saturating instance sits at 0 with borrow every cycle.
    cycle(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      check("sat_dn_q", 32'(s_q), 0);
      check("sat_dn_borrow", 32'(s_borrow), 1);
      check("wrap_dn_q", 32'(w_q), 32'(9 - i));
      check("wrap_dn_borrow", 32'(w_borrow), (i == 0) ? 1 : 0);
    end

    // Load of 13 clamps to 9 and beats the up request.
    cycle(1'b1, 4'd13, 1'b1, 1'b1, 1'b0);
    check("ld_clamp_q", 32'(w_q), 9);
    check("ld_carry", 32'(w_carry), 0);
    check("ld_tc_up", 32'(w_tc_up), 1);
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    check("ld_up_q", 32'(w_q), 0);
    check("ld_up_carry", 32'(w_carry), 1);
    check("sat_up_q", 32'(s_q), 9);
    check("sat_up_carry", 32'(s_carry), 1);
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    check("sat_up2_q", 32'(s_q), 9);
    check("sat_up2_carry", 32'(s_carry), 1);
    check("wrap_up2_carry", 32'(w_carry), 0);

    // up & down together hold; cnt_en low holds.
    cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    check("both_q", 32'(w_q), 5);
    check("both_carry", 32'(w_carry), 0);
    check("both_borrow", 32'(w_borrow), 0);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check("noen_q", 32'(w_q), 5);
    check("noen_carry", 32'(w_carry), 0);

    // STEP=4: 8+4-(9+1) = 2 with carry; 2+(9+1)-4 = 8 with borrow.
    cycle(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    check("step4_up_q", 32'(f_q), 2);
    check("step4_up_carry", 32'(f_carry), 1);
    cycle(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    check("step4_dn_q", 32'(f_q), 8);
    check("step4_dn_borrow", 32'(f_borrow), 1);

`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    check("ovf_set", 32'(w_ovf), 1);
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    flag_clr = 1'b1;
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    check("ovf_set_wins", 32'(w_ovf), 1);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("ovf_clr", 32'(w_ovf), 0);
    flag_clr = 1'b0;
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    check("unf_set", 32'(w_unf), 1);
`endif

    // Asynchronous reset mid-count with a wrap pending.
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    cnt_en = 1'b1;
    up     = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_q", 32'(w_q), 0);
    check("async_rst_tc_dn", 32'(w_tc_dn), 1);
`ifdef UPDOWN_PARAM_STICKY_FLAGS_EN
    check("async_rst_ovf", 32'(w_ovf), 0);
    check("async_rst_unf", 32'(w_unf), 0);
`endif
    cnt_en = 1'b0;
    up     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_q", 32'(w_q), 0);
    check("post_rst_carry", 32'(w_carry), 0);
    check("post_rst_borrow", 32'(w_borrow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
